// File: rtl/uart_pkg.sv
// Shared UART constants, serializer state encoding and the helpers that
// derive bit timing from the clock and bit-rate parameters.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_HZ       = 24_000_000;
    localparam int unsigned DEFAULT_BIT_RATE     = 115_200;
    localparam int unsigned DEFAULT_PAYLOAD_BITS = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

    localparam int unsigned CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BIT_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem[rd_ptr];

    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;

    // NOTE: storage has no reset; an entry is only readable after it was written.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state updates are non-blocking so every register sees pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a byte FIFO feeding a start/data/stop serializer
// whose line output comes straight from a flop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int unsigned PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned CW    = cnt_width(CPB);
    localparam int unsigned IDX_W = cnt_width(PAYLOAD_BITS);

    localparam logic [CW-1:0]    CNT_LAST = CW'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic [PAYLOAD_BITS-1:0]   shift_q, shift_d;
    logic                      txd_q, txd_d;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [PAYLOAD_BITS-1:0]   fifo_rd_data;
    logic                      bit_tick;

    uart_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst     (rst),
        .wr_en   (tx_valid && tx_ready),
        .wr_data (tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_q != ST_IDLE) || (fifo_level != '0);
    assign uart_txd = txd_q;
    assign bit_tick = (bit_cnt_q == CNT_LAST);

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    // Back-to-back frames: reload straight into START, no idle bit.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the registered state one cycle later, glitch-free.
    always_comb begin
        unique case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and randomized checks of uart_tx_buffered against a queue-based
// model of the byte stream and the frame timing rules.
module tb_uart_tx_buffered;

    localparam int C      = 24_000_000 / 115_200;
    localparam int C_SLOW = 50_000_000 / 9_600;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [4:0] fifo_level;

    logic       rst_s;
    logic [7:0] tx_data_s;
    logic       tx_valid_s;
    logic       tx_ready_s;
    logic       uart_txd_s;
    logic       tx_busy_s;
    logic [4:0] fifo_level_s;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    uart_tx_buffered u_dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level)
    );

    uart_tx_buffered #(
        .CLK_HZ   (50_000_000),
        .BIT_RATE (9_600)
    ) u_dut_slow (
        .clk_in     (clk_in),
        .rst        (rst_s),
        .tx_data    (tx_data_s),
        .tx_valid   (tx_valid_s),
        .tx_ready   (tx_ready_s),
        .uart_txd   (uart_txd_s),
        .tx_busy    (tx_busy_s),
        .fifo_level (fifo_level_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int w;
        @(negedge clk_in);
        tx_data  = d;
        tx_valid = 1'b1;
        w = 0;
        while (!tx_ready && w < 20 * C) begin
            @(negedge clk_in);
            w++;
        end
        check("push_accepted_in_time", 32'(w < 20 * C), 1);
        @(posedge clk_in);
        exp_q.push_back(d);
        #1 tx_valid = 1'b0;
    endtask

    // Decodes one frame from the next negedge on; bit timing is checked per bit.
    task automatic check_frame(input int max_wait, input string tag);
        logic [7:0] d;
        logic [9:0] bits;
        int         w;
        int         good;
        w = 0;
        do begin
            @(negedge clk_in);
            w++;
        end while (uart_txd !== 1'b0 && w < max_wait);
        check({tag, "_start_seen"}, 32'(uart_txd), 0);
        check({tag, "_model_nonempty"}, 32'(exp_q.size() != 0), 1);
        if (uart_txd === 1'b0 && exp_q.size() != 0) begin
            d    = exp_q.pop_front();
            bits = {1'b1, d, 1'b0};
            for (int b = 0; b < 10; b++) begin
                good = 0;
                for (int k = 0; k < C; k++) begin
                    if (!(b == 0 && k == 0)) @(negedge clk_in);
                    if (uart_txd === bits[b]) good++;
                end
                check($sformatf("%s_byte%02h_bit%0d_cycles", tag, d, b), good, C);
            end
        end
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (cyc < target) @(negedge clk_in);
    endtask

    initial begin
        #(10 * 400_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  b;
        int unsigned n_acc;
        int          w;
        int          lows;
        int          cnt;

        rst = 1'b1;  rst_s = 1'b1;
        tx_valid = 1'b0; tx_data = '0;
        tx_valid_s = 1'b0; tx_data_s = '0;
        repeat (3) @(negedge clk_in);
        check("rst_txd", 32'(uart_txd), 1);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_level", 32'(fifo_level), 0);
        rst = 1'b0; rst_s = 1'b0;
        repeat (5) @(negedge clk_in);
        check("no_frame_after_reset", 32'(uart_txd), 1);

        // Single byte with exact start latency.
        push(8'h41);
        check("single_busy_on_accept", 32'(tx_busy), 1);
        @(posedge clk_in); #1;
        check("single_txd_n1", 32'(uart_txd), 1);
        @(posedge clk_in); #1;
        check("single_txd_n2", 32'(uart_txd), 0);
        check_frame(4, "single");
        @(negedge clk_in);
        check("single_busy_after", 32'(tx_busy), 0);
        check("single_idle_line", 32'(uart_txd), 1);
        check("single_level_after", 32'(fifo_level), 0);

        // Back-to-back burst: frames must abut.
        repeat (20) @(negedge clk_in);
        push(8'h55); push(8'hAA); push(8'h00);
        check_frame(4, "burst0");
        check_frame(1, "burst1");
        check_frame(1, "burst2");

        // Fill the buffer while a frame is on the line.
        repeat (20) @(negedge clk_in);
        push(8'($urandom));
        for (int i = 0; i < 16; i++) push(8'($urandom));
        void'(exp_q.pop_front());
        @(negedge clk_in);
        check("full_level", 32'(fifo_level), 16);
        check("full_ready", 32'(tx_ready), 0);
        b = 8'($urandom);
        tx_data  = b;
        tx_valid = 1'b1;
        w = 0;
        while (!tx_ready && w < 12 * C) begin
            @(negedge clk_in);
            w++;
        end
        check("full_held_until_pop", 32'(w < 12 * C), 1);
        check("full_level_after_pop", 32'(fifo_level), 15);
        @(posedge clk_in);
        exp_q.push_back(b);
        #1 tx_valid = 1'b0;
        check("full_level_refilled", 32'(fifo_level), 16);
        check_frame(4, "full_first");
        @(negedge clk_in);
        check("full_next_start", 32'(uart_txd), 0);
        rst = 1'b1;
        #1;
        check("async_rst_txd", 32'(uart_txd), 1);
        check("async_rst_level", 32'(fifo_level), 0);
        check("async_rst_ready", 32'(tx_ready), 1);
        check("async_rst_busy", 32'(tx_busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_in);
        rst = 1'b0;

        // Push on the very edge the serializer pops, at level 3.
        repeat (10) @(negedge clk_in);
        push(8'($urandom));
        n_acc = cyc;
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) push(8'($urandom));
        @(negedge clk_in);
        check("simul_level_before", 32'(fifo_level), 3);
        wait_cycle(n_acc + 10 * C);
        check("simul_level_at_pop", 32'(fifo_level), 3);
        b = 8'($urandom);
        tx_data  = b;
        tx_valid = 1'b1;
        check("simul_ready", 32'(tx_ready), 1);
        @(posedge clk_in);
        exp_q.push_back(b);
        #1 tx_valid = 1'b0;
        check("simul_level_after", 32'(fifo_level), 3);
        check_frame(4, "simul0");
        for (int i = 1; i < 4; i++) check_frame(1, $sformatf("simul%0d", i));

        // Reset in the middle of 8'hF0 with five bytes queued.
        repeat (20) @(negedge clk_in);
        push(8'hF0);
        n_acc = cyc;
        for (int i = 0; i < 5; i++) push(8'($urandom));
        wait_cycle(n_acc + 2 + 4 * C + C / 2);
        check("midrst_bit3", 32'(uart_txd), 0);
        check("midrst_queued", 32'(fifo_level), 5);
        wait_cycle(n_acc + 2 + 5 * C + C / 2);
        check("midrst_bit4", 32'(uart_txd), 1);
        rst = 1'b1;
        #1;
        check("midrst_txd", 32'(uart_txd), 1);
        check("midrst_level", 32'(fifo_level), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        lows = 0;
        for (int k = 0; k < 3 * C; k++) begin
            @(negedge clk_in);
            if (uart_txd !== 1'b1) lows++;
        end
        check("midrst_no_frames", lows, 0);
        check("midrst_busy", 32'(tx_busy), 0);

        // Slow instance: 50 MHz / 9600 bit/s, alternating bits to time each one.
        @(negedge clk_in);
        tx_data_s  = 8'h55;
        tx_valid_s = 1'b1;
        @(posedge clk_in);
        #1 tx_valid_s = 1'b0;
        w = 0;
        do begin
            @(negedge clk_in);
            w++;
        end while (uart_txd_s !== 1'b0 && w < 10);
        check("slow_start_seen", 32'(uart_txd_s), 0);
        for (int b = 0; b < 4; b++) begin
            cnt = 0;
            while (uart_txd_s === 1'(b % 2) && cnt < C_SLOW + 10) begin
                cnt++;
                @(negedge clk_in);
            end
            check($sformatf("slow_bit%0d_cycles", b), cnt, C_SLOW);
        end
        rst_s = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_s = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
